driver_sched: RTL
=================

// Module: driver_sched
// PURPOSE
//  Multi-channel, parametrised successor to the single-channel fixed-depth driver.
//  - Per channel, accepts 1-cycle trigger pulses and schedules a stretched output pulse.
//  - The output is immediate or delayed by a per-trigger offset; the offset is latched at insertion.
//  - Sits between test-sequence control logic and the DUT-facing drive strobes.
// PARAMETERS
//  N_CH      2   number of independent channels
//  DEPTH     32  schedule horizon in cycles; power of two, >=2
//  HOLD_CYC  4   output high time per fire event, cycles; 1..255
//  DW        $clog2(DEPTH)  delay field width (derived, not overridable)
// PORTS
//  CLK         in   1         clock, all logic on rising edge
//  RST         in   1         synchronous reset, active-high
//  DRIV        in   N_CH      per-channel 1-cycle trigger
//  SHIFT       in   N_CH      1: delayed by DRIV_FRONT; 0: immediate
//  DRIV_FRONT  in   N_CH*DW   per-channel delay, ch k at [k*DW +: DW]
//  DRIV_VALID  out  N_CH      stretched drive output
//  DRIV_FIRE   out  N_CH      1-cycle pulse on each fire event
//  SCHED_BUSY  out  N_CH      1 while any fire is pending in the schedule
//  COLLIDE     out  N_CH      1-cycle pulse: trigger merged into an already-set slot
// BEHAVIOUR
//  - Reset: RST sampled high clears the schedule and hold counters. All outputs are 0 from the next edge. Inputs are ignored that cycle.
//  - Trigger sampled at edge t with delay D (D = DRIV_FRONT if SHIFT, else 0):
//    - fire event at t+1+D;
//    - DRIV_FIRE high for exactly cycle t+1+D;
//    - DRIV_VALID high for cycles t+1+D .. t+D+HOLD_CYC.
//  - SHIFT=1 with DRIV_FRONT=0 is identical to SHIFT=0, including the stretch.
//  - D is captured at insertion. Later DRIV_FRONT changes never move pending fires.
//  - Schedule per channel is a DEPTH-slot timing wheel. Slot for delay D is set; slots advance one per cycle.
//  - Multiple pending fires are allowed, up to DEPTH.
//  - Trigger targeting an already-set slot: slot stays set (single fire), COLLIDE pulses at t+1.
//  - Fire while DRIV_VALID high: hold counter reloads to HOLD_CYC. Output stays high, no gap. DRIV_FIRE pulses again.
//  - Immediate trigger and a scheduled fire in the same cycle: one fire event, no COLLIDE.
//  - SCHED_BUSY = OR of pending slots, registered. It drops on the cycle the last pending fire occurs.
//  - Channels are fully independent. No cross-channel arbitration.
//  - No backpressure: every trigger is accepted.
// CONFIGURATION
//  DRIVER_CANCEL_EN defined:
//   - adds input CANCEL [N_CH], after COLLIDE in the port list;
//   - CANCEL[k] sampled high clears all pending slots and the hold counter of ch k; DRIV_VALID[k] and SCHED_BUSY[k] are 0 next cycle;
//   - DRIV[k] in the same cycle as CANCEL[k] is accepted after the clear, so only the new trigger survives.
//  DRIVER_CANCEL_EN undefined: no CANCEL port. Pending fires always complete.
// STRUCTURE
//  - Package driver_pkg: HOLD_W=8 counter width; DEPTH legality check function; delay-field slice helper.
//  - Sub-module driver_chan: one channel (wheel, hold counter, flags), instantiated N_CH times via generate.
//  - Top does port slicing only.
// TESTING (N_CH=2, DEPTH=32, HOLD_CYC=4)
//  1. Ch0 DRIV, SHIFT=0 at t=10 -> DRIV_VALID[0] high 11..14, DRIV_FIRE[0] at 11 only, ch1 quiet.
//  2. Ch1 DRIV, SHIFT=1, FRONT=5 at t=10; FRONT changed to 20 at t=11 -> DRIV_VALID[1] high 16..19, SCHED_BUSY[1] high 11..15.
//  3. Ch0 FRONT=31 at t=0, then FRONT=30 at t=1 -> both fire at 32 (one slot), COLLIDE[0] at 2, single DRIV_FIRE at 32.
//  4. Ch0 immediate at t=10 and t=12 -> DRIV_VALID high 11..16 contiguous, DRIV_FIRE at 11 and 13.
//  5. Ch0 FRONT=8 at t=10, RST at t=12 -> all outputs 0 from 13, no fire at 19.
//  6. With DRIVER_CANCEL_EN: ch0 FRONT=6 at t=0; CANCEL with DRIV, SHIFT=0 at t=3 -> fire at 4 only, nothing at 7.

Source files
------------

// File: rtl/driver_pkg.sv
// Shared constants and helpers for the multi-channel drive scheduler.
package driver_pkg;

  localparam int unsigned HOLD_W = 8;

  // Schedule horizon must be a power of two and at least 2.
  function automatic bit depth_ok(input int unsigned depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

  // LSB of channel ch's delay field in the packed DRIV_FRONT bus.
  function automatic int unsigned delay_lsb(input int unsigned ch, input int unsigned dw);
    return ch * dw;
  endfunction

endpackage

// File: rtl/driver_chan.sv
// One scheduler channel: timing wheel, hold counter and status flags.
// Optional CANCEL input when DRIVER_CANCEL_EN is defined.
module driver_chan
  import driver_pkg::*;
#(
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned HOLD_CYC = 4,
  parameter int unsigned DW       = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          driv,
  input  logic          shift,
  input  logic [DW-1:0] front,
`ifdef DRIVER_CANCEL_EN
  input  logic          cancel,
`endif
  output logic          driv_valid,
  output logic          driv_fire,
  output logic          sched_busy,
  output logic          collide
);

  logic [DEPTH-1:0]  slots_q, slots_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              fire_q, fire_d;
  logic              coll_q, coll_d;
  logic              busy_q;
  logic [DW-1:0]     dly;
  logic              clr;

`ifdef DRIVER_CANCEL_EN
  assign clr = cancel;
`else
  assign clr = 1'b0;
`endif

  // Slot i holds a fire due i+1 edges from now; slot 0 fires on the coming edge.
  always_comb begin
    dly     = shift ? front : '0;
    slots_d = clr ? '0 : (slots_q >> 1);
    fire_d  = (driv && (dly == '0)) || (slots_q[0] && !clr);
    coll_d  = 1'b0;
    if (driv && (dly != '0)) begin
      coll_d                  = slots_d[dly - DW'(1)];
      slots_d[dly - DW'(1)]   = 1'b1;
    end
    if (fire_d) begin
      hold_d = HOLD_W'(HOLD_CYC);
    end else if (clr || (hold_q == '0)) begin
      hold_d = '0;
    end else begin
      hold_d = hold_q - HOLD_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slots_q <= '0;
      hold_q  <= '0;
      fire_q  <= 1'b0;
      coll_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      slots_q <= slots_d;
      hold_q  <= hold_d;
      fire_q  <= fire_d;
      coll_q  <= coll_d;
      busy_q  <= |slots_d;
    end
  end

  assign driv_valid = (hold_q != '0);
  assign driv_fire  = fire_q;
  assign sched_busy = busy_q;
  assign collide    = coll_q;

endmodule

// File: rtl/driver_sched.sv
// Multi-channel trigger scheduler top: slices buses onto per-channel instances.
// Optional feature macro: DRIVER_CANCEL_EN (adds CANCEL input).
module driver_sched
  import driver_pkg::*;
#(
  parameter int unsigned  N_CH     = 2,
  parameter int unsigned  DEPTH    = 32,
  parameter int unsigned  HOLD_CYC = 4,
  localparam int unsigned DW       = $clog2(DEPTH)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [N_CH-1:0]      DRIV,
  input  logic [N_CH-1:0]      SHIFT,
  input  logic [N_CH*DW-1:0]   DRIV_FRONT,
  output logic [N_CH-1:0]      DRIV_VALID,
  output logic [N_CH-1:0]      DRIV_FIRE,
  output logic [N_CH-1:0]      SCHED_BUSY,
  output logic [N_CH-1:0]      COLLIDE
`ifdef DRIVER_CANCEL_EN
  ,
  input  logic [N_CH-1:0]      CANCEL
`endif
);

  if (!depth_ok(DEPTH)) begin : g_bad_depth
    $fatal(1, "driver_sched: DEPTH must be a power of two >= 2");
  end

  if ((HOLD_CYC < 1) || (HOLD_CYC > 255)) begin : g_bad_hold
    $fatal(1, "driver_sched: HOLD_CYC must be in 1..255");
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_chan
    driver_chan #(
      .DEPTH   (DEPTH),
      .HOLD_CYC(HOLD_CYC),
      .DW      (DW)
    ) u_chan (
      .clk       (CLK),
      .rst       (RST),
      .driv      (DRIV[k]),
      .shift     (SHIFT[k]),
      .front     (DRIV_FRONT[delay_lsb(k, DW) +: DW]),
`ifdef DRIVER_CANCEL_EN
      .cancel    (CANCEL[k]),
`endif
      .driv_valid(DRIV_VALID[k]),
      .driv_fire (DRIV_FIRE[k]),
      .sched_busy(SCHED_BUSY[k]),
      .collide   (COLLIDE[k])
    );
  end

endmodule
